// File: rtl/wb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter
//
// Wishbone classic arbiter. It places up to NUM_MANAGERS managers onto one
// peripheral-side bus. Grants are round-robin. A grant is locked for as long
// as the owner holds CYC. A per-transfer timeout guard stops a transfer that
// has stalled: the owner gets a dummy acknowledge carrying ERR_DATA, and the
// bus is released.
//
// Ports
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   A_ADR_I/A_DAT_I/A_SEL_I   packed manager address, write data and byte
//                             selects (manager k at [32k +: 32] / [4k +: 4])
//   A_WE_I/A_STB_I/A_CYC_I    per-manager control
//   A_DAT_O/A_ACK_O           read data and acknowledge back to the managers
//   DAT_I/ACK_I               peripheral read data and acknowledge
//   ADR_O/DAT_O/SEL_O         forwarded address, write data and byte selects
//   WE_O/STB_O/CYC_O          forwarded control
//   grant_o                   one-hot current owner, zero when idle
//   timeout_o                 one-cycle pulse when a transfer is terminated
// -----------------------------------------------------------------------------
module wb_rr_arbiter #(
    parameter int          NUM_MANAGERS   = 2,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic [32*NUM_MANAGERS-1:0] A_ADR_I,
    input  logic [32*NUM_MANAGERS-1:0] A_DAT_I,
    input  logic [4*NUM_MANAGERS-1:0]  A_SEL_I,
    input  logic [NUM_MANAGERS-1:0]    A_WE_I,
    input  logic [NUM_MANAGERS-1:0]    A_STB_I,
    input  logic [NUM_MANAGERS-1:0]    A_CYC_I,
    output logic [32*NUM_MANAGERS-1:0] A_DAT_O,
    output logic [NUM_MANAGERS-1:0]    A_ACK_O,
    input  logic [31:0]                DAT_I,
    input  logic                       ACK_I,
    output logic [31:0]                ADR_O,
    output logic [31:0]                DAT_O,
    output logic [3:0]                 SEL_O,
    output logic                       WE_O,
    output logic                       STB_O,
    output logic                       CYC_O,
    output logic [NUM_MANAGERS-1:0]    grant_o,
    output logic                       timeout_o
);

    localparam int IDX_W  = (NUM_MANAGERS > 1) ? $clog2(NUM_MANAGERS) : 1;
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWN,
        ST_TERM
    } state_t;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  gidx, gidx_nxt;   // index of the current owner
    logic [IDX_W-1:0]  ptr, ptr_nxt;     // round-robin search start
    logic [TCNT_W-1:0] tcnt, tcnt_nxt;   // stalled-strobe cycle count

    logic [NUM_MANAGERS-1:0] req;
    logic                    found;
    logic [IDX_W-1:0]        winner;
    int                      cand;

    assign req = A_CYC_I & A_STB_I;

    // Winner search: the first requester at or after ptr, wrapping upward.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = 0;
        for (int i = 0; i < NUM_MANAGERS; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_MANAGERS) cand = cand - NUM_MANAGERS;
            if (!found && req[IDX_W'(cand)]) begin
                found  = 1'b1;
                winner = IDX_W'(cand);
            end
        end
    end

    // NOTE: each signal written in an always_comb gets a default first.
    // Without a default, some paths leave the signal unassigned, and the
    // tool then infers a latch.
    always_comb begin
        state_nxt = state;
        gidx_nxt  = gidx;
        ptr_nxt   = ptr;
        tcnt_nxt  = '0;
        case (state)
            ST_IDLE: begin
                if (found) begin
                    state_nxt = ST_OWN;
                    gidx_nxt  = winner;
                    ptr_nxt   = (winner == IDX_W'(NUM_MANAGERS - 1)) ? '0
                                                                     : winner + IDX_W'(1);
                end
            end
            ST_OWN: begin
                if (!CYC_O) begin
                    // The owner releases the bus. A pending strobe gets no ack.
                    state_nxt = ST_IDLE;
                    gidx_nxt  = '0;
                end else if (ACK_I) begin
                    tcnt_nxt = '0;
                end else if (STB_O) begin
                    if (tcnt == TCNT_LAST) state_nxt = ST_TERM;
                    else                   tcnt_nxt  = tcnt + TCNT_W'(1);
                end else begin
                    tcnt_nxt = tcnt;
                end
            end
            ST_TERM: begin
                // Force a re-arbitration, even if the owner still holds CYC.
                state_nxt = ST_IDLE;
                gidx_nxt  = '0;
            end
            default: begin
                state_nxt = ST_IDLE;
                gidx_nxt  = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments. Every flop then
    // samples its inputs before any flop updates, so the evaluation order of
    // the blocks does not change the result.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= ST_IDLE;
            gidx  <= '0;
            ptr   <= '0;
            tcnt  <= '0;
        end else begin
            state <= state_nxt;
            gidx  <= gidx_nxt;
            ptr   <= ptr_nxt;
            tcnt  <= tcnt_nxt;
        end
    end

    // Output mux. Every output is zero in IDLE. OWN forwards the owner's
    // signals combinationally. TERM gives the owner a dummy ack with ERR_DATA.
    always_comb begin
        ADR_O     = '0;
        DAT_O     = '0;
        SEL_O     = '0;
        WE_O      = 1'b0;
        STB_O     = 1'b0;
        CYC_O     = 1'b0;
        A_DAT_O   = '0;
        A_ACK_O   = '0;
        grant_o   = '0;
        timeout_o = (state == ST_TERM);
        for (int k = 0; k < NUM_MANAGERS; k++) begin
            if (state != ST_IDLE && gidx == IDX_W'(k)) begin
                grant_o[k] = 1'b1;
                if (state == ST_OWN) begin
                    ADR_O               = A_ADR_I[32*k +: 32];
                    DAT_O               = A_DAT_I[32*k +: 32];
                    SEL_O               = A_SEL_I[4*k +: 4];
                    WE_O                = A_WE_I[k];
                    STB_O               = A_STB_I[k];
                    CYC_O               = A_CYC_I[k];
                    A_DAT_O[32*k +: 32] = DAT_I;
                    A_ACK_O[k]          = ACK_I & A_STB_I[k];
                end else begin
                    A_DAT_O[32*k +: 32] = ERR_DATA;
                    A_ACK_O[k]          = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_rr_arbiter
//
// Bench for wb_rr_arbiter. Two instances share one clock and one reset:
//   dut2: NUM_MANAGERS=2, TIMEOUT_CYCLES=8 (basic transfers, locking, timeout,
//         reset in the middle of a transfer)
//   dut3: NUM_MANAGERS=3, default timeout (round-robin fairness)
// Inputs change 1 time unit after the rising edge. Outputs are sampled on the
// falling edge, so each check sees the combinational outputs of that cycle.
// -----------------------------------------------------------------------------
module tb_wb_rr_arbiter;

    localparam logic [31:0] A0   = 32'h3000_0004;
    localparam logic [31:0] A1   = 32'h4000_0008;
    localparam logic [31:0] D0   = 32'h1234_5678;
    localparam logic [31:0] D1   = 32'hCAFE_0001;
    localparam logic [31:0] PDAT = 32'h5A5A_A5A5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---- dut2 signals ----
    logic [63:0] adr2, dat2, a_dat_o2;
    logic [7:0]  sel2;
    logic [1:0]  we2, stb2, cyc2, a_ack_o2, grant2;
    logic [31:0] pdat2, adr_o2, dat_o2;
    logic [3:0]  sel_o2;
    logic        ack2, we_o2, stb_o2, cyc_o2, timeout2;

    // ---- dut3 signals ----
    logic [95:0] adr3, dat3, a_dat_o3;
    logic [11:0] sel3;
    logic [2:0]  we3, stb3, cyc3, a_ack_o3, grant3;
    logic [31:0] pdat3, adr_o3, dat_o3;
    logic [3:0]  sel_o3;
    logic        ack3, we_o3, stb_o3, cyc_o3, timeout3;

    wb_rr_arbiter #(.NUM_MANAGERS(2), .TIMEOUT_CYCLES(8)) dut2 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .A_ADR_I(adr2), .A_DAT_I(dat2), .A_SEL_I(sel2),
        .A_WE_I(we2), .A_STB_I(stb2), .A_CYC_I(cyc2),
        .A_DAT_O(a_dat_o2), .A_ACK_O(a_ack_o2),
        .DAT_I(pdat2), .ACK_I(ack2),
        .ADR_O(adr_o2), .DAT_O(dat_o2), .SEL_O(sel_o2),
        .WE_O(we_o2), .STB_O(stb_o2), .CYC_O(cyc_o2),
        .grant_o(grant2), .timeout_o(timeout2)
    );

    wb_rr_arbiter #(.NUM_MANAGERS(3)) dut3 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .A_ADR_I(adr3), .A_DAT_I(dat3), .A_SEL_I(sel3),
        .A_WE_I(we3), .A_STB_I(stb3), .A_CYC_I(cyc3),
        .A_DAT_O(a_dat_o3), .A_ACK_O(a_ack_o3),
        .DAT_I(pdat3), .ACK_I(ack3),
        .ADR_O(adr_o3), .DAT_O(dat_o3), .SEL_O(sel_o3),
        .WE_O(we_o3), .STB_O(stb_o3), .CYC_O(cyc_o3),
        .grant_o(grant3), .timeout_o(timeout3)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int to_pulses = 0;

    always @(negedge clk) if (timeout2 === 1'b1) to_pulses++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One table row is one clock cycle of dut2: inputs plus expected outputs.
    typedef struct {
        logic        rst;
        logic [1:0]  cyc;
        logic [1:0]  stb;
        logic        ack;
        logic [1:0]  e_grant;
        logic        e_cyc;
        logic        e_stb;
        logic [1:0]  e_ack;
        logic [31:0] e_adr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [1:0] c, input logic [1:0] s, input logic k,
                       input logic [1:0] g, input logic ec, input logic es,
                       input logic [1:0] ea, input logic [31:0] adr);
        vec_t v;
        v.rst = r; v.cyc = c; v.stb = s; v.ack = k;
        v.e_grant = g; v.e_cyc = ec; v.e_stb = es; v.e_ack = ea; v.e_adr = adr;
        vecs.push_back(v);
    endtask

    logic [31:0] exp_dato;
    logic [3:0]  exp_sel;
    logic        exp_we;
    logic [63:0] exp_adat;
    logic [2:0]  acked;
    logic [2:0]  prev_g3;
    int          order[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Manager 0 writes D0 to A0. Manager 1 reads A1.
        adr2 = {A1, A0}; dat2 = {D1, D0}; sel2 = {4'h3, 4'hF}; we2 = 2'b01;
        cyc2 = '0; stb2 = '0; ack2 = 1'b0; pdat2 = PDAT;
        adr3 = {32'hA2, 32'hA1, 32'hA0}; dat3 = '0; sel3 = '1; we3 = '0;
        cyc3 = '0; stb3 = '0; ack3 = 1'b0; pdat3 = 32'h0000_1111;

        // ---- reset: every output is zero from the first reset edge, even with requests ----
        rst = 1'b1;
        tick();
        cyc2 = 2'b11; stb2 = 2'b11; ack2 = 1'b1;
        cyc3 = 3'b111; stb3 = 3'b111; ack3 = 1'b1;
        @(negedge clk);
        check("reset_dut2_ctrl", 64'({grant2, a_ack_o2, we_o2, stb_o2, cyc_o2, timeout2, sel_o2}), 64'(0));
        check("reset_dut2_data", 64'(|{adr_o2, dat_o2, a_dat_o2}), 64'(0));
        check("reset_dut3_ctrl", 64'({grant3, a_ack_o3, we_o3, stb_o3, cyc_o3, timeout3, sel_o3}), 64'(0));
        check("reset_dut3_data", 64'(|{adr_o3, dat_o3, a_dat_o3}), 64'(0));
        tick();
        rst = 1'b0;
        cyc2 = '0; stb2 = '0; ack2 = 1'b0;
        cyc3 = '0; stb3 = '0; ack3 = 1'b0;

        // ---- table: single write, simultaneous requests, locked block ----
        //   rst   cyc    stb    ack   grant  cyc_o stb_o  a_ack  adr
        add(1'b0, 2'b01, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0); // 0 idle, m0 requests
        add(1'b0, 2'b01, 2'b01, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, A0);    // 1 m0 owns
        add(1'b0, 2'b01, 2'b01, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, A0);    // 2 wait
        add(1'b0, 2'b01, 2'b01, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01, A0);    // 3 peripheral ack
        add(1'b0, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, A0);    // 4 CYC dropped
        add(1'b1, 2'b11, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0); // 5 reset while idle
        add(1'b0, 2'b11, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0); // 6 both request
        add(1'b0, 2'b11, 2'b11, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01, A0);    // 7 m0 first
        add(1'b0, 2'b10, 2'b10, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, A0);    // 8 m0 drops
        add(1'b0, 2'b10, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0); // 9 dead cycle
        add(1'b0, 2'b11, 2'b11, 1'b1, 2'b10, 1'b1, 1'b1, 2'b10, A1);    // 10 m1 beat 1
        add(1'b0, 2'b11, 2'b01, 1'b0, 2'b10, 1'b1, 1'b0, 2'b00, A1);    // 11 STB gap
        add(1'b0, 2'b11, 2'b11, 1'b1, 2'b10, 1'b1, 1'b1, 2'b10, A1);    // 12 beat 2
        add(1'b0, 2'b11, 2'b01, 1'b1, 2'b10, 1'b1, 1'b0, 2'b00, A1);    // 13 gap, stray ACK_I
        add(1'b0, 2'b11, 2'b11, 1'b1, 2'b10, 1'b1, 1'b1, 2'b10, A1);    // 14 beat 3
        add(1'b0, 2'b11, 2'b11, 1'b0, 2'b10, 1'b1, 1'b1, 2'b00, A1);    // 15 wait state
        add(1'b0, 2'b11, 2'b11, 1'b1, 2'b10, 1'b1, 1'b1, 2'b10, A1);    // 16 beat 4
        add(1'b0, 2'b01, 2'b01, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, A1);    // 17 m1 drops
        add(1'b0, 2'b01, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0); // 18 dead cycle
        add(1'b0, 2'b01, 2'b01, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01, A0);    // 19 m0 served
        add(1'b0, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, A0);    // 20 m0 drops
        add(1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0); // 21 idle

        foreach (vecs[i]) begin
            rst = vecs[i].rst; cyc2 = vecs[i].cyc; stb2 = vecs[i].stb; ack2 = vecs[i].ack;
            exp_dato = (vecs[i].e_grant == 2'b01) ? D0 : (vecs[i].e_grant == 2'b10) ? D1 : 32'h0;
            exp_sel  = (vecs[i].e_grant == 2'b01) ? 4'hF : (vecs[i].e_grant == 2'b10) ? 4'h3 : 4'h0;
            exp_we   = (vecs[i].e_grant == 2'b01);
            exp_adat = {vecs[i].e_grant[1] ? PDAT : 32'h0, vecs[i].e_grant[0] ? PDAT : 32'h0};
            @(negedge clk);
            check($sformatf("row%0d_ctrl", i),
                  64'({grant2, cyc_o2, stb_o2, a_ack_o2, timeout2, we_o2, sel_o2}),
                  64'({vecs[i].e_grant, vecs[i].e_cyc, vecs[i].e_stb, vecs[i].e_ack, 1'b0, exp_we, exp_sel}));
            check($sformatf("row%0d_fwd", i), {adr_o2, dat_o2}, {vecs[i].e_adr, exp_dato});
            check($sformatf("row%0d_rdata", i), a_dat_o2, exp_adat);
            tick();
        end
        rst = 1'b0;

        // ---- timeout: a read that is never acked, then an ack on the threshold cycle ----
        cyc2 = 2'b01; stb2 = 2'b01; ack2 = 1'b0;
        @(negedge clk);
        check("to_req_idle", 64'(grant2), 64'(0));
        tick();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("to_stall%0d", i), 64'({grant2, cyc_o2, stb_o2, a_ack_o2, timeout2}),
                  64'({2'b01, 1'b1, 1'b1, 2'b00, 1'b0}));
            tick();
        end
        @(negedge clk);
        check("term_ctrl", 64'({grant2, cyc_o2, stb_o2, a_ack_o2, timeout2}),
              64'({2'b01, 1'b0, 1'b0, 2'b01, 1'b1}));
        check("term_err_data", a_dat_o2, {32'h0, 32'hDEAD_BEEF});
        tick();
        @(negedge clk);
        check("after_term_idle", 64'({grant2, cyc_o2, a_ack_o2, timeout2}), 64'(0));
        tick();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check($sformatf("re_stall%0d", i), 64'({grant2, cyc_o2, timeout2}), 64'({2'b01, 1'b1, 1'b0}));
            tick();
        end
        ack2 = 1'b1;
        @(negedge clk);
        check("ack_at_threshold", 64'({a_ack_o2, timeout2}), 64'({2'b01, 1'b0}));
        check("ack_at_threshold_data", a_dat_o2, {32'h0, PDAT});
        tick();
        cyc2 = 2'b00; stb2 = 2'b00; ack2 = 1'b0;
        @(negedge clk);
        check("no_term_after_ack", 64'({grant2, cyc_o2, a_ack_o2, timeout2}), 64'({2'b01, 1'b0, 2'b00, 1'b0}));
        tick();
        @(negedge clk);
        check("late_ack_release_idle", 64'(grant2), 64'(0));
        check("timeout_pulse_count", 64'(to_pulses), 64'(1));
        tick();

        // ---- reset in the middle of a transfer: abort, no ack, ptr back to 0 ----
        cyc2 = 2'b01; stb2 = 2'b01;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("pre_reset_own", 64'(grant2), 64'(2'b01));
        rst = 1'b1; cyc2 = 2'b11; stb2 = 2'b11;
        tick();
        rst = 1'b0; ack2 = 1'b1;
        @(negedge clk);
        check("midreset_ctrl", 64'({grant2, a_ack_o2, we_o2, stb_o2, cyc_o2, timeout2, sel_o2}), 64'(0));
        check("midreset_data", 64'(|{adr_o2, dat_o2, a_dat_o2}), 64'(0));
        tick();
        @(negedge clk);
        check("post_reset_m0_wins", 64'(grant2), 64'(2'b01));
        cyc2 = 2'b00; stb2 = 2'b00; ack2 = 1'b0;
        tick();
        tick();

        // ---- fairness on three managers; each drops CYC for one cycle after its ack ----
        acked = '0; prev_g3 = '0;
        cyc3 = 3'b111; stb3 = 3'b111; ack3 = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c % 8 == 0) check($sformatf("fair_onehot_c%0d", c), 64'($countones(grant3) <= 1), 64'(1));
            if (grant3 != 3'b000 && prev_g3 == 3'b000) begin
                for (int k = 0; k < 3; k++) if (grant3[k]) order.push_back(k);
            end
            prev_g3 = grant3;
            acked   = a_ack_o3;
            tick();
            cyc3 = ~acked; stb3 = ~acked;
        end
        cyc3 = '0; stb3 = '0; ack3 = 1'b0;
        check("fair_grant_count", 64'(order.size() >= 6), 64'(1));
        for (int i = 0; i < 6; i++) begin
            if (i < order.size()) check($sformatf("fair_order%0d", i), 64'(order[i]), 64'(i % 3));
        end
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
